// File: rtl/pe_array_result_drainer_pkg.sv
// Shared NVP constants and the result drainer state encoding.
package NVP_v1_constants;

    localparam int NUMBER_OF_PES_PER_ARRAY              = 16;
    localparam int ACCUMULATOR_BIT_WIDTH                = 32;
    localparam int SUPPORTED_MAX_NUMBER_OF_KERNEL_STEPS = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drainer_state_e;

endpackage : NVP_v1_constants

// File: rtl/pe_array_result_drainer.sv
// Snapshots the PE array result bus and serializes it step-major onto a valid/ready stream.
// Optional macro PE_RESULT_DRAINER_RELU_EN clamps negative words to zero before the o_data register.
module pe_array_result_drainer #(
    parameter int NUMBER_OF_PES_PER_ARRAY              = NVP_v1_constants::NUMBER_OF_PES_PER_ARRAY,
    parameter int ACCUMULATOR_BIT_WIDTH                = NVP_v1_constants::ACCUMULATOR_BIT_WIDTH,
    parameter int SUPPORTED_MAX_NUMBER_OF_KERNEL_STEPS = NVP_v1_constants::SUPPORTED_MAX_NUMBER_OF_KERNEL_STEPS,
    localparam int KERNEL_STEPS_COUNTER_BIT_WIDTH      = $clog2(SUPPORTED_MAX_NUMBER_OF_KERNEL_STEPS) + 1
) (
    input  logic                                      clk,
    input  logic                                      resetn,
    input  logic                                      i_capture,
    input  logic [NUMBER_OF_PES_PER_ARRAY-1:0]
                 [SUPPORTED_MAX_NUMBER_OF_KERNEL_STEPS-1:0]
                 [ACCUMULATOR_BIT_WIDTH-1:0]          i_result,
    input  logic [KERNEL_STEPS_COUNTER_BIT_WIDTH-1:0] i_number_of_kernel_steps,
    output logic [ACCUMULATOR_BIT_WIDTH-1:0]          o_data,
    output logic                                      o_valid,
    input  logic                                      i_ready,
    output logic                                      o_last,
    output logic                                      o_busy,
    output logic                                      o_capture_overflow
);

    import NVP_v1_constants::*;

    localparam int N  = NUMBER_OF_PES_PER_ARRAY;
    localparam int S  = SUPPORTED_MAX_NUMBER_OF_KERNEL_STEPS;
    localparam int W  = ACCUMULATOR_BIT_WIDTH;
    localparam int KW = KERNEL_STEPS_COUNTER_BIT_WIDTH;
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = (S > 1) ? $clog2(S) : 1;
    localparam logic [PW-1:0] PE_LAST = PW'(N - 1);

    drainer_state_e state_q, state_d;

    logic [N-1:0][S-1:0][W-1:0] snapshot;
    logic [PW-1:0]              pe_idx, next_pe;
    logic [SW-1:0]              step_idx, next_step, last_step;
    logic [KW-1:0]              n_steps_q, eff_steps;
    logic                       handshake, last_hs;
    logic                       capture_accept, capture_reject;

    function automatic logic [W-1:0] shape_word(input logic [W-1:0] w);
`ifdef PE_RESULT_DRAINER_RELU_EN
        return w[W-1] ? '0 : w;
`else
        return w;
`endif
    endfunction

    assign handshake = o_valid && i_ready;
    assign last_hs   = handshake && o_last;
    assign last_step = SW'(n_steps_q - KW'(1));
    assign next_pe   = (pe_idx == PE_LAST) ? '0 : pe_idx + PW'(1);
    assign next_step = (pe_idx == PE_LAST) ? step_idx + SW'(1) : step_idx;

    // Zero steps still drains one step; oversized requests clamp to the storage depth.
    always_comb begin
        // NOTE: default first so every path assigns it and no latch is inferred.
        eff_steps = i_number_of_kernel_steps;
        if (i_number_of_kernel_steps == '0)
            eff_steps = KW'(1);
        else if (i_number_of_kernel_steps > KW'(S))
            eff_steps = KW'(S);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_capture) state_d = DRAIN;
            DRAIN:   if (last_hs && !i_capture) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The final handshake of a drain is the only point a new capture can chain in.
    always_comb begin
        capture_accept = i_capture && ((state_q == IDLE) || last_hs);
        capture_reject = i_capture && (state_q == DRAIN) && !last_hs;
        o_busy         = (state_q == DRAIN);
    end

    // NOTE: the snapshot is pure storage, only ever read behind o_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (capture_accept) snapshot <= i_result;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
            pe_idx             <= '0;
            step_idx           <= '0;
            n_steps_q          <= '0;
            o_data             <= '0;
            o_valid            <= 1'b0;
            o_last             <= 1'b0;
            o_capture_overflow <= 1'b0;
        end else begin
            o_capture_overflow <= capture_reject;
            if (capture_accept) begin
                // Word (0,0) comes straight from the bus since the snapshot updates on this same edge.
                pe_idx    <= '0;
                step_idx  <= '0;
                n_steps_q <= eff_steps;
                o_valid   <= 1'b1;
                o_data    <= shape_word(i_result[0][0]);
                o_last    <= (PE_LAST == '0) && (eff_steps == KW'(1));
            end else if (handshake) begin
                if (o_last) begin
                    o_valid <= 1'b0;
                    o_last  <= 1'b0;
                end else begin
                    pe_idx   <= next_pe;
                    step_idx <= next_step;
                    o_data   <= shape_word(snapshot[next_pe][next_step]);
                    o_last   <= (next_pe == PE_LAST) && (next_step == last_step);
                end
            end
        end
    end

endmodule : pe_array_result_drainer
